// File: rtl/benes_ctrl_loader.sv
// Double-buffered control-word loader for a Benes interconnect.
// Switch settings for one permutation stream into a shadow register, one
// W-bit word per transfer. A commit moves the complete shadow into the active
// register in one cycle. The active register drives every 2x2 switch.
module benes_ctrl_loader #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int STAGES = 2 * $clog2(N) - 1,
  localparam int NUM_SW = STAGES * N / 2,
  localparam int WORDS  = (NUM_SW + W - 1) / W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      s_ctrl_data,
  input  logic              s_ctrl_valid,
  output logic              s_ctrl_ready,
  input  logic              i_swap,
  input  logic              i_clear,
  output logic [NUM_SW-1:0] o_switch_set,
  output logic              o_cfg_valid,
  output logic              o_loaded,
  output logic              o_swap_done
);

  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [NUM_SW-1:0]   shadow_q, shadow_d;
  logic [NUM_SW-1:0]   active_q, active_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                swap_done_q, swap_done_d;
  logic                xfer;

  // Next-state, shadow write and commit logic; clear overrides swap and transfers.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    cfg_valid_d  = cfg_valid_q;
    swap_done_d  = 1'b0;
    s_ctrl_ready = (state_q == LOAD) && !rst;
    o_loaded     = (state_q == FULL);
    xfer         = s_ctrl_valid && s_ctrl_ready;

    if (i_clear) begin
      state_d = LOAD;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (xfer) begin
            // Bit j of the shadow belongs to word j/W, bit j%W; bits of the
            // last word beyond NUM_SW have no destination and are dropped.
            for (int j = 0; j < NUM_SW; j++) begin
              if (wcnt_q == CW'(j / W)) begin
                shadow_d[j] = s_ctrl_data[j % W];
              end
            end
            if (wcnt_q == LAST_WORD) begin
              state_d = FULL;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (i_swap) begin
            active_d    = shadow_q;
            cfg_valid_d = 1'b1;
            swap_done_d = 1'b1;
            state_d     = LOAD;
          end
        end
        default: begin
          state_d = LOAD;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  // State, counter and configuration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wcnt_q      <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      cfg_valid_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_valid_q <= cfg_valid_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign o_switch_set = active_q;
  assign o_cfg_valid  = cfg_valid_q;
  assign o_swap_done  = swap_done_q;

endmodule

// File: doc/benes_ctrl_loader.md
# benes_ctrl_loader

Double-buffered control-word loader for the Benes interconnect. It collects switch settings for one full permutation from a narrow valid/ready stream into a shadow register. On a commit pulse it transfers them atomically into the active register, whose bits drive the `switch_set` input of every 2x2 switch in the network. Reconfiguration can therefore be streamed in while the current permutation is still routing data.

## Interface
Parameters:
- `N`, 8: Benes network port count; power of 2, at least 4.
- `W`, 8: control stream word width, at least 1.
- Derived (localparam) `STAGES` = 2*log2(N)-1.
- Derived (localparam) `NUM_SW` = STAGES*N/2.
- Derived (localparam) `WORDS` = ceil(NUM_SW/W).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_ctrl_data`  in  W  control word.
- `s_ctrl_valid`  in  1  control word valid.
- `s_ctrl_ready`  out  1  loader can accept a word.
- `i_swap`  in  1  commit request: shadow to active.
- `i_clear`  in  1  abort a partial load.
- `o_switch_set`  out  NUM_SW  active settings; bit j drives `switch_set` of switch j (0 = bar, 1 = cross).
- `o_cfg_valid`  out  1  active register holds a committed configuration.
- `o_loaded`  out  1  shadow complete and waiting for commit.
- `o_swap_done`  out  1  one-cycle pulse: active updated this cycle.

## Operation
- Switch index j = stage*(N/2) + position. Stage 0 is on the input side. Position 0 is the switch on ports 0/1.
- Word k, bit b is written to shadow bit k*W+b. Bits of the last word at or above NUM_SW are ignored.
- A word transfers when `s_ctrl_valid & s_ctrl_ready` at a rising edge. The word counter `wcnt` (width clog2(WORDS+1)) increments per transfer.
- States: LOAD and FULL.
- LOAD:
  - `s_ctrl_ready`=1.
  - Transfer with wcnt==WORDS-1: go to FULL and set wcnt=0.
  - Any other transfer: wcnt+1.
- FULL:
  - `s_ctrl_ready`=0 and `o_loaded`=1.
  - On `i_swap`: active <= shadow, `o_cfg_valid`<=1, pulse `o_swap_done`, go to LOAD.
- `i_swap` in LOAD is ignored, including the cycle in which the final word transfers. No partial commit ever occurs.
- `i_clear` applies in either state:
  - Go to LOAD with wcnt=0.
  - The shadow is discarded (contents don't-care).
  - Active register and `o_cfg_valid` are unchanged.
  - `i_clear` has priority over `i_swap` and over a concurrent word transfer (word dropped).
- The active register changes only on a committed swap. `o_switch_set` is a pure register output with no combinational path from any input.
- Reset state:
  - State is LOAD, wcnt=0.
  - Shadow and active are all zeros (all switches bar, identity permutation).
  - `o_cfg_valid`=0, `o_loaded`=0, `o_swap_done`=0.
  - `s_ctrl_ready`=0 during any cycle with `rst` high, 1 from the first cycle after.
- Reset mid-load or in FULL discards everything, including the active configuration.

## Timing
- Stream-to-shadow: 1 cycle per word. A full load takes WORDS cycles of back-to-back valid.
- Final-word transfer at edge t: `o_loaded`=1 and `s_ctrl_ready`=0 from t.
- `i_swap` sampled high in FULL at edge t:
  - `o_switch_set` holds the new value from t.
  - `o_swap_done`=1 for the cycle after t only.
  - `s_ctrl_ready`=1 and `o_loaded`=0 from t.
- Minimum full reconfiguration period: WORDS+1 cycles (load, then swap).
- A word can be accepted in the cycle right after the swap edge.
- `i_swap` held high continuously commits exactly once per completed load.

## Test plan
- Reset then load, N=8, W=8 (NUM_SW=20, WORDS=3): words 0xA5, 0x3C, 0xF7 back-to-back, then `i_swap` -> `o_loaded` rises after the 3rd word. One cycle after swap, `o_switch_set`=20'h73CA5, `o_cfg_valid`=1, `o_swap_done` high exactly 1 cycle.
- Backpressure: hold valid with a 4th word 0x11 while in FULL -> `s_ctrl_ready`=0 and the word is not consumed. After swap it is accepted as word 0 of the next load. Active stays 20'h73CA5 until the next swap.
- Early swap: pulse `i_swap` after 2 words, and again in the same cycle as the 3rd word -> no change to `o_switch_set`, `o_swap_done` stays 0. A later swap commits.
- Clear priority: after 2 words, assert `i_clear` and `i_swap` together -> wcnt=0, active unchanged. Three new words 0xFF, 0xFF, 0x0F plus swap give 20'hFFFFF.
- Clear with concurrent transfer: `i_clear` in the same cycle as the 3rd word -> word dropped, state LOAD, `o_loaded`=0.
- Reset in FULL after a committed config -> `o_switch_set`=0, `o_cfg_valid`=0, `o_loaded`=0. `s_ctrl_ready` is 0 during reset and 1 on the next cycle.
